mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between two requesters:
  - an instruction-fetch port (read-only);
  - a data port (read/write).
- Sits between a multi-cycle MIPS core and a unified instruction/data memory.
- Implements a req/ack handshake, a configurable-latency access sequencer and a tie-break policy.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-ported memory with a LAT-cycle access sequencer.
// Tie-break: data wins by default; define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [1:0]        grant_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              start;
  logic              pick_d;
  logic              last_cycle;

  assign start      = (state == IDLE) && (i_req || d_req);
  assign last_cycle = (state == ACCESS) && (cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  assign pick_d = d_req & (~i_req | ~last_d);

  // Round-robin pointer: 1 when the data port was served most recently.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (start) begin
      last_d <= pick_d;
    end else begin
      last_d <= last_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // Next-state and access counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched transaction and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      adr_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      grant_q   <= 2'b00;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        grant_q <= pick_d ? 2'b10 : 2'b01;
        adr_q   <= pick_d ? d_adr : i_adr;
        wdata_q <= pick_d ? d_wdata : '0;
        we_q    <= pick_d & d_we;
      end else if (state == RESP) begin
        grant_q <= 2'b00;
      end
      // Writes never disturb the data port's last read word.
      if (last_cycle && !we_q) begin
        if (grant_q[1]) begin
          d_rdata_q <= mem_rdata;
        end else begin
          i_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_adr   = (state == ACCESS) ? adr_q : '0;
  assign mem_wdata = (state == ACCESS) ? wdata_q : '0;
  assign mem_read  = (state == ACCESS) && !we_q && !rst;
  assign mem_write = last_cycle && we_q && !grant_q[0] && !rst;
  assign busy      = (state != IDLE);
  assign grant     = grant_q;
  assign i_ack     = (state == RESP) && grant_q[0];
  assign d_ack     = (state == RESP) && grant_q[1];
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_adr = 32'd0, d_adr = 32'd0, d_wdata = 32'd0;
  logic [31:0] i_rdata, d_rdata, mem_adr, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_read, mem_write, busy;
  logic [1:0]  grant;

  logic        b_i_req = 1'b0;
  logic [31:0] b_i_adr = 32'd0;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_adr, b_mem_wdata, b_mem_rdata;
  logic        b_i_ack, b_d_ack, b_mem_read, b_mem_write, b_busy;
  logic [1:0]  b_grant;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_adr(b_i_adr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'd0), .d_wdata(32'd0), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .grant(b_grant)
  );

  assign mem_rdata   = mem[mem_adr[7:0]];
  assign b_mem_rdata = mem[b_mem_adr[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_adr[7:0]] <= mem_wdata;
  end

  // Reference model: one transaction at a time, tracked by cycles elapsed since its grant edge.
  bit          m_act = 1'b0, m_port_d = 1'b0, m_we = 1'b0, m_last_d = 1'b0;
  int          m_el = 0;
  logic [31:0] m_adr = 32'd0, m_wd = 32'd0, m_irdata = 32'd0, m_drdata = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_last_d = 1'b0; m_irdata = 32'd0; m_drdata = 32'd0;
    end else if (m_act) begin
      if (m_el == LAT) begin
        m_act = 1'b0;
      end else begin
        if (m_el == LAT - 1) begin
          if (m_we) ref_mem[m_adr[7:0]] = m_wd;
          else if (m_port_d) m_drdata = ref_mem[m_adr[7:0]];
          else m_irdata = ref_mem[m_adr[7:0]];
        end
        m_el++;
      end
    end else if (i_req || d_req) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_port_d = !m_last_d;
`else
        m_port_d = 1'b1;
`endif
      end else begin
        m_port_d = d_req;
      end
      m_last_d = m_port_d;
      m_act    = 1'b1;
      m_el     = 0;
      m_adr    = m_port_d ? d_adr : i_adr;
      m_we     = m_port_d && d_we;
      m_wd     = m_port_d ? d_wdata : 32'd0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit acc, rsp;
      acc = m_act && (m_el < LAT);
      rsp = m_act && (m_el == LAT);
      check("busy", {31'd0, busy}, {31'd0, m_act});
      check("grant", {30'd0, grant}, m_act ? (m_port_d ? 32'd2 : 32'd1) : 32'd0);
      check("i_ack", {31'd0, i_ack}, {31'd0, rsp && !m_port_d});
      check("d_ack", {31'd0, d_ack}, {31'd0, rsp && m_port_d});
      check("mem_adr", mem_adr, acc ? m_adr : 32'd0);
      check("mem_wdata", mem_wdata, acc ? m_wd : 32'd0);
      check("mem_read", {31'd0, mem_read}, {31'd0, acc && !m_we && !rst});
      check("mem_write", {31'd0, mem_write}, {31'd0, acc && m_we && (m_el == LAT - 1) && !rst});
      check("i_rdata", i_rdata, m_irdata);
      check("d_rdata", d_rdata, m_drdata);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; b_i_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Issue one request on a port and wait (bounded) for its ack.
  task automatic run_req(input bit is_d, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         output int lat, output int reads, output int writes,
                         output logic [1:0] g, output logic [31:0] rdata, output bit got);
    lat = 0; reads = 0; writes = 0; got = 1'b0; g = 2'b00; rdata = 32'd0;
    if (is_d) begin d_req = 1'b1; d_we = we; d_adr = adr; d_wdata = wd; end
    else begin i_req = 1'b1; i_adr = adr; end
    for (int n = 1; n <= 40 && !got; n++) begin
      tick();
      lat = n;
      if (n == 1) g = grant;
      if (mem_read) reads++;
      if (mem_write) writes++;
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        rdata = is_d ? d_rdata : i_rdata;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    check("req_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int lat, rd, wr, td, ti, cnt, gap, last_t;
    logic [1:0] g;
    logic [31:0] rdata;
    logic [7:0] seq;
    bit got;

    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'h8C010004; ref_mem[8'h10] = 32'h8C010004;
    mem[8'h30] = 32'h11112222; ref_mem[8'h30] = 32'h11112222;
    for (int i = 0; i < 4; i++) begin
      mem[8'h40 + i * 4] = 32'hA0000000 + i; ref_mem[8'h40 + i * 4] = 32'hA0000000 + i;
    end

    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_grant", {30'd0, grant}, 32'd0);
    check("reset_rdata", i_rdata | d_rdata, 32'd0);

    // Fetch from 0x10.
    run_req(1'b0, 1'b0, 32'h10, 32'd0, lat, rd, wr, g, rdata, got);
    check("fetch_latency", lat, 32'd3);
    check("fetch_rdata", rdata, 32'h8C010004);
    check("fetch_reads", rd, 32'd2);
    check("fetch_grant", {30'd0, g}, 32'd1);
    tick();

    // Write then read back 0x20.
    run_req(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, lat, rd, wr, g, rdata, got);
    check("write_strobes", wr, 32'd1);
    check("write_grant", {30'd0, g}, 32'd2);
    tick();
    check("write_ack_once", {31'd0, d_ack}, 32'd0);
    check("write_mem", mem[8'h20], 32'hDEADBEEF);
    run_req(1'b1, 1'b0, 32'h20, 32'd0, lat, rd, wr, g, rdata, got);
    check("readback", rdata, 32'hDEADBEEF);
    tick();

    // Tie straight after reset: data first, fetch LAT+2 cycles later.
    do_reset();
    i_req = 1'b1; i_adr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h20;
    td = -1; ti = -1;
    for (int n = 1; n <= 40 && ti < 0; n++) begin
      tick();
      if (d_ack) begin td = n; d_req = 1'b0; end
      if (i_ack) begin ti = n; i_req = 1'b0; end
    end
    check("tie_d_first", {31'd0, td > 0 && td < ti}, 32'd1);
    check("tie_gap", ti - td, 32'd4);
    tick();

    // Both held for 8 grants.
    do_reset();
    i_req = 1'b1; i_adr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h20;
    seq = 8'd0; cnt = 0; ti = 0;
    for (int n = 0; n < 200 && cnt < 8; n++) begin
      tick();
      if (d_ack) begin seq[cnt] = 1'b1; cnt++; end
      else if (i_ack) begin seq[cnt] = 1'b0; cnt++; ti++; end
    end
    check("held_count", cnt, 32'd8);
`ifdef ARB_ROUND_ROBIN_EN
    check("held_seq_rr", {24'd0, seq}, 32'h55);
`else
    check("held_seq_fixed", {24'd0, seq}, 32'hFF);
    check("held_no_i_ack", ti, 32'd0);
`endif

    // Reset during the final ACCESS cycle of a write to 0x30.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h30; d_wdata = 32'hCAFEF00D;
    tick();
    tick();
    check("abort_pre_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1; d_req = 1'b0;
    #1;
    check("abort_write_gated", {31'd0, mem_write}, 32'd0);
    tick();
    rst = 1'b0;
    check("abort_outputs", {busy, grant, i_ack, d_ack, mem_read, mem_write}, 32'd0);
    check("abort_bus", mem_adr | mem_wdata | i_rdata | d_rdata, 32'd0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (d_ack) cnt++;
    end
    check("abort_no_ack", cnt, 32'd0);
    check("abort_mem", mem[8'h30], 32'h11112222);

    // LAT=1 instance: back-to-back fetches.
    b_i_req = 1'b1; b_i_adr = 32'h40; cnt = 0; last_t = 0;
    for (int n = 1; n <= 60 && cnt < 4; n++) begin
      tick();
      if (b_i_ack) begin
        check("lat1_rdata", b_i_rdata, 32'hA0000000 + cnt);
        gap = n - last_t;
        check("lat1_spacing", gap, cnt == 0 ? 32'd2 : 32'd3);
        last_t = n; cnt++;
        b_i_adr = 32'h40 + cnt * 4;
      end
    end
    b_i_req = 1'b0;
    check("lat1_count", cnt, 32'd4);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (i_req && i_ack) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_adr = 32'($urandom_range(0, 63)) << 2;
      end
      if (d_req && d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
        d_adr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
      end
      tick();
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) cnt++;
    end
    check("mem_image", cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
